rr_arb_mux: RTL
===============

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, 2..16.
REQ-002 Parameter DATA_W, default 8: data width per channel, 1..64.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, N_CH: bit i high means channel i offers data.
REQ-006 Port in_data, input, N_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port in_ready, output, N_CH: one-hot or zero; bit i high means channel i is accepted this cycle.
REQ-008 Port out_valid, output, 1: the output register holds a word.
REQ-009 Port out_data, output, DATA_W: registered word.
REQ-010 Port out_ch, output, CH_W = max(1, clog2(N_CH)): index of the source channel of out_data.
REQ-011 Port out_ready, input, 1: downstream accepts the word when out_valid and out_ready are both high.

Function
REQ-012 Two states, implied by out_valid: EMPTY (0) and FULL (1).
REQ-013 load = !out_valid | out_ready; a transfer may be accepted only when load is high.
REQ-014 Arbitration is round-robin from pointer ptr (CH_W bits). The winner is the first channel with in_valid high, scanning ptr, ptr+1, ... and wrapping modulo N_CH.
REQ-015 in_ready[winner] = load & |in_valid; all other in_ready bits are 0. in_ready is combinational from in_valid, out_valid, out_ready and ptr.
REQ-016 On an accept edge:
- out_data <= the winner's data
- out_ch <= winner
- out_valid <= 1
- ptr <= (winner+1) mod N_CH, wrapping correctly for non-power-of-two N_CH
REQ-017 When load is high and no in_valid is set: out_valid <= 0, and ptr, out_data and out_ch hold.
REQ-018 When FULL and out_ready is low: out_valid, out_data, out_ch and ptr hold stable, and in_ready = 0.
REQ-019 Simultaneous consume and accept: when FULL, out_ready is high and a request is present, the new word replaces the old one in the same edge. There is no bubble, so the block sustains throughput of 1 word/cycle.
REQ-020 Latency: an accepted word appears on out_data exactly 1 cycle after the accept edge.
REQ-021 A single channel held valid continuously is granted every cycle that load is high (no forced idle).
REQ-022 Starvation bound: any channel holding in_valid high is granted within N_CH accepts.
REQ-023 in_valid may drop without having been accepted; the block has no memory of unaccepted requests.

Reset
REQ-024 While rst is high, asynchronously: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-025 While rst is high, in_ready=0.
REQ-026 Reset asserted mid-transfer discards the held word. The first post-reset grant favours channel 0.

Structure
REQ-027 Shared package rr_mux_pkg holds:
- the clog2-based CH_W width function
- default parameter constants N_CH_DEF=4 and DATA_W_DEF=8
REQ-028 One sub-module, rr_prio_pick: combinational rotating-priority picker. Inputs are the request vector and ptr; outputs are the one-hot grant, the winner index and an any-request flag.
REQ-029 All registers sit in rr_arb_mux. The total is 120-400 lines of RTL.

Verification
REQ-030 Reset check: assert rst mid-stream with out_valid=1 -> out_valid=0, out_ch=0 and in_ready=0 immediately, without waiting for a clock edge.
REQ-031 Fairness: N_CH=4, all in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; in_ready rotates 0001,0010,0100,1000.
REQ-032 Skip and wrap: ptr=2, in_valid=0011 -> channel 0 granted, then ptr=1; next cycle channel 1 granted, then ptr=2.
REQ-033 Back-pressure: FULL with out_data=8'hA5 and out_ready=0 for 3 cycles while in_valid=1111 -> out_data stays A5, in_ready=0000 and ptr is unchanged.
REQ-034 Non-power-of-two: N_CH=3, DATA_W=16, all valid -> out_ch cycles 0,1,2,0 and never reaches 3.
REQ-035 Drain: in_valid=0000 with out_ready=1 after one word -> out_valid falls 1 cycle after consumption and out_data holds its last value.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// ============================================================================
// rr_mux_pkg : shared types, defaults and width helper for rr_arb_mux
// Rev 1.0
// ============================================================================
`default_nettype none

package rr_mux_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 8;

  // Output register occupancy; the state bit is exported directly as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_prio_pick.sv
// ============================================================================
// rr_prio_pick : combinational rotating-priority picker (first request at or
//                after ptr, wrapping modulo N_CH)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_prio_pick
  import rr_mux_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  localparam logic [CH_W:0] C_N = (CH_W + 1)'(N_CH);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [CH_W-1:0]   off;
  logic [CH_W:0]     sum;

  always_comb begin
    dbl   = {req, req};
    // rot[k] is the request of channel (ptr + k) mod N_CH
    rot   = N_CH'(dbl >> ptr);
    off   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = CH_W'(k);
    end
    sum   = {1'b0, ptr} + {1'b0, off};
    if (sum >= C_N) sum = sum - C_N;
    idx   = sum[CH_W-1:0];
    any   = |req;
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant[i] = any && (idx == CH_W'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// ============================================================================
// rr_arb_mux : N_CH-to-1 round-robin arbiter with a single registered output
//              stage sustaining one word per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb_mux
  import rr_mux_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int CH_W   = ch_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  localparam logic [CH_W-1:0] C_LAST = CH_W'(N_CH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   ptr_nxt;
  logic [N_CH-1:0]   grant;
  logic              any;
  logic              load;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  rr_prio_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign out_valid = (state_q == ST_FULL);
  assign load      = !out_valid || out_ready;
  assign accept    = load && any;
  // rst gates in_ready directly: the emptied register would otherwise offer load.
  assign in_ready  = rst ? '0 : (grant & {N_CH{load}});
  assign ptr_nxt   = (win == C_LAST) ? '0 : win + 1'b1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) state_d = any ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      out_data <= '0;
      out_ch   <= '0;
      ptr      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data <= sel_data;
        out_ch   <= win;
        ptr      <= ptr_nxt;
      end
    end
  end

endmodule

`default_nettype wire
